// File: rtl/fmul_issue_q.sv
// fmul_issue_q
// Issue/result stage in front of the combinational single-precision
// multiplier. Operand pairs and their destination tags queue up in an
// in-order FIFO. The head entry drives the multiplier, and the returned
// product is captured into a result register together with its tag.
// Valid/ready handshakes on the dispatch side and the writeback side let
// either side stall without affecting the other.
//
// Optional feature: define FMUL_ISSUE_BYPASS_EN to let an operation that
// arrives at an empty, idle queue skip the FIFO. That operation is then
// captured at the same edge it is accepted.

module fmul_issue_q #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_x1,
    input  logic [31:0]              in_x2,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [31:0]              mul_x1,
    output logic [31:0]              mul_x2,
    input  logic [31:0]              mul_y,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_y,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // FIFO storage; contents are don't-care after reset
    logic [31:0]      mem_x1  [DEPTH];
    logic [31:0]      mem_x2  [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             fifo_empty;
    logic             push;
    logic             res_free;
    logic             cap;
    logic             fifo_push;
    logic             load_res;
    logic [TAG_W-1:0] load_tag;

`ifdef FMUL_ISSUE_BYPASS_EN
    logic             bypass;
`endif

    // Handshake decode. in_ready looks only at registered occupancy, so a
    // pop in the same cycle never frees a slot for a push.
    always_comb begin
        fifo_empty = (count == '0);
        in_ready   = (count < FULL_COUNT);
        push       = in_valid && in_ready;
        res_free   = !res_valid || res_ready;
        cap        = !fifo_empty && res_free;
    end

`ifdef FMUL_ISSUE_BYPASS_EN
    // An op that finds the queue empty and the result slot free goes straight to the multiplier
    always_comb begin
        bypass    = push && fifo_empty && res_free;
        fifo_push = push && !bypass;
        load_res  = cap || bypass;
        load_tag  = bypass ? in_tag : mem_tag[rd_ptr];
    end

    // Multiplier operands come from the head entry, the bypassing input, or zero when idle
    always_comb begin
        mul_x1 = 32'h0;
        mul_x2 = 32'h0;
        if (!fifo_empty) begin
            mul_x1 = mem_x1[rd_ptr];
            mul_x2 = mem_x2[rd_ptr];
        end else if (bypass) begin
            mul_x1 = in_x1;
            mul_x2 = in_x2;
        end
    end
`else
    // Every accepted op goes through the FIFO; capture only ever takes the head entry
    always_comb begin
        fifo_push = push;
        load_res  = cap;
        load_tag  = mem_tag[rd_ptr];
    end

    // Multiplier operands come from the head entry, or zero while the queue is empty
    always_comb begin
        mul_x1 = 32'h0;
        mul_x2 = 32'h0;
        if (!fifo_empty) begin
            mul_x1 = mem_x1[rd_ptr];
            mul_x2 = mem_x2[rd_ptr];
        end
    end
`endif

    // Write the accepted op at the tail; reset blocks the write so nothing half-lands
    always_ff @(posedge clk) begin
        if (!rst && fifo_push) begin
            mem_x1[wr_ptr]  <= in_x1;
            mem_x2[wr_ptr]  <= in_x2;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    // Tail and head pointers; DEPTH is a power of two so natural overflow wraps them
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (cap) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy moves only when exactly one of push-into-FIFO or capture happens
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({fifo_push, cap})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Result register. The product and tag hold their last values once the consumer takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_y     <= 32'h0;
            res_tag   <= '0;
        end else if (load_res) begin
            res_valid <= 1'b1;
            res_y     <= mul_y;
            res_tag   <= load_tag;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fmul_issue_q.sv
// tb_fmul_issue_q
// Directed and randomized bench for fmul_issue_q. A stand-in multiplier
// answers mul_x1/mul_x2 combinationally. A queue-based reference model
// predicts occupancy, head operands and the result register. A separate
// push-order scoreboard checks that results are consumed in order.
// Define FMUL_ISSUE_BYPASS_EN to exercise the bypass build.

module tb_fmul_issue_q;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
`ifdef FMUL_ISSUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
    localparam int LAT    = 1;
`else
    localparam bit BYPASS = 1'b0;
    localparam int LAT    = 2;
`endif

    typedef struct {
        logic [31:0]      x1;
        logic [31:0]      x2;
        logic [TAG_W-1:0] tag;
    } op_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [31:0]            in_x1 = 32'h0;
    logic [31:0]            in_x2 = 32'h0;
    logic [TAG_W-1:0]       in_tag = '0;
    logic [31:0]            mul_x1;
    logic [31:0]            mul_x2;
    logic [31:0]            mul_y;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [31:0]            res_y;
    logic [TAG_W-1:0]       res_tag;
    logic [$clog2(DEPTH):0] count;

    int compared   = 0;
    int mismatched = 0;
    int consumed   = 0;

    op_t              mq[$];
    logic [TAG_W-1:0] orderQ[$];
    bit               mrv  = 1'b0;
    logic [31:0]      my   = 32'h0;
    logic [TAG_W-1:0] mtag = '0;

    fmul_issue_q #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
        .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_tag(res_tag), .count(count)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: exact products for the directed pairs, a fixed scramble otherwise
    function automatic logic [31:0] fakeMul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
        if (a == 32'hBF800000 && b == 32'h40000000) return 32'hC0000000;
        if (a == 32'h00000000 && b == 32'h40000000) return 32'h00000000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
    endfunction

    assign mul_y = fakeMul(mul_x1, mul_x2);

    task automatic compareVal(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit          bypNow;
        logic [31:0] ex1;
        logic [31:0] ex2;
        bypNow = BYPASS && in_valid && (mq.size() == 0) && (!mrv || res_ready);
        ex1 = (mq.size() > 0) ? mq[0].x1 : (bypNow ? in_x1 : 32'h0);
        ex2 = (mq.size() > 0) ? mq[0].x2 : (bypNow ? in_x2 : 32'h0);
        compareVal("count",     32'(count),     32'(mq.size()));
        compareVal("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
        compareVal("res_valid", 32'(res_valid), 32'(mrv));
        compareVal("res_y",     res_y,          my);
        compareVal("res_tag",   32'(res_tag),   32'(mtag));
        compareVal("mul_x1",    mul_x1,         ex1);
        compareVal("mul_x2",    mul_x2,         ex2);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] x1, input logic [31:0] x2,
                                 input logic [TAG_W-1:0] tag, input logic rr);
        op_t no;
        op_t head;
        bit  free;
        bit  mpush;
        bit  mcap;
        bit  mbyp;
        bit  take;
        in_valid  = v;
        in_x1     = x1;
        in_x2     = x2;
        in_tag    = tag;
        res_ready = rr;
        free  = !mrv || rr;
        mpush = v && (mq.size() < DEPTH);
        mcap  = (mq.size() > 0) && free;
        mbyp  = BYPASS && mpush && (mq.size() == 0) && free;
        take  = mrv && rr;
        if (take) begin
            if (orderQ.size() > 0) begin
                compareVal("order_tag", 32'(res_tag), 32'(orderQ.pop_front()));
            end else begin
                compareVal("order_underflow", 32'(orderQ.size()), 32'd1);
            end
            consumed++;
        end
        @(posedge clk);
        if (mcap) begin
            head = mq.pop_front();
            mrv  = 1'b1;
            my   = fakeMul(head.x1, head.x2);
            mtag = head.tag;
        end else if (mbyp) begin
            mrv  = 1'b1;
            my   = fakeMul(x1, x2);
            mtag = tag;
        end else if (take) begin
            mrv = 1'b0;
        end
        if (mpush) begin
            orderQ.push_back(tag);
            if (!mbyp) begin
                no.x1  = x1;
                no.x2  = x2;
                no.tag = tag;
                mq.push_back(no);
            end
        end
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        mq.delete();
        orderQ.delete();
        mrv  = 1'b0;
        my   = 32'h0;
        mtag = '0;
        #1;
        rst = 1'b0;
        checkOutput();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (mrv || mq.size() > 0); i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, '0, 1'b1);
        end
        compareVal("drain_done", 32'(mrv || mq.size() > 0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0]      expY[3];
        logic [TAG_W-1:0] nextTag;
        int               acc;
        int               base;
        bit               v;

        expY[0] = 32'h40100000;
        expY[1] = 32'hC0000000;
        expY[2] = 32'h00000000;

        $display("[TB] reset");
        doReset();
        compareVal("reset_count", 32'(count), 32'd0);
        compareVal("reset_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] single op 2.0*3.0");
        applyStimulus(1'b1, 32'h40000000, 32'h40400000, 5'd3, 1'b1);
        for (int i = 1; i < LAT; i++) applyStimulus(1'b0, 32'h0, 32'h0, '0, 1'b1);
        compareVal("t1_res_valid", 32'(res_valid), 32'd1);
        compareVal("t1_res_y", res_y, 32'h40C00000);
        compareVal("t1_res_tag", 32'(res_tag), 32'd3);
        applyStimulus(1'b0, 32'h0, 32'h0, '0, 1'b1);
        compareVal("t1_count", 32'(count), 32'd0);

        $display("[TB] back-to-back ops");
        for (int i = 0; i < 3 + LAT - 1; i++) begin
            case (i)
                0:       applyStimulus(1'b1, 32'h3FC00000, 32'h3FC00000, 5'd1, 1'b1);
                1:       applyStimulus(1'b1, 32'hBF800000, 32'h40000000, 5'd2, 1'b1);
                2:       applyStimulus(1'b1, 32'h00000000, 32'h40000000, 5'd3, 1'b1);
                default: applyStimulus(1'b0, 32'h0, 32'h0, '0, 1'b1);
            endcase
            if (i >= LAT - 1) begin
                compareVal("t2_res_y", res_y, expY[i-LAT+1]);
                compareVal("t2_res_tag", 32'(res_tag), 32'(i - LAT + 2));
            end
        end
        drain();

        $display("[TB] backpressure fill");
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, 5'(8 + i), 1'b0);
        end
        compareVal("t3_count_full", 32'(count), 32'(DEPTH));
        compareVal("t3_in_ready", 32'(in_ready), 32'd0);
        compareVal("t3_res_valid", 32'(res_valid), 32'd1);
        applyStimulus(1'b1, $urandom, $urandom, 5'd30, 1'b0);
        compareVal("t3_ignored", 32'(count), 32'(DEPTH));
        base = consumed;
        drain();
        compareVal("t3_drained", 32'(consumed - base), 32'(DEPTH + 1));

        $display("[TB] push refused while full");
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, 5'(16 + i), 1'b0);
        end
        compareVal("t4_full", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 32'h11111111, 32'h22222222, 5'd25, 1'b1);
        compareVal("t4_refused_count", 32'(count), 32'(DEPTH - 1));
        compareVal("t4_ready_again", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 32'h11111111, 32'h22222222, 5'd25, 1'b0);
        compareVal("t4_accepted_count", 32'(count), 32'(DEPTH));
        drain();

        $display("[TB] random wrap with toggling res_ready");
        acc = 0;
        nextTag = 5'd0;
        for (int c = 0; c < 200 && acc < 2 * DEPTH + 1; c++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v && count < DEPTH) acc++;
            applyStimulus(v, $urandom, $urandom, nextTag, (c % 2) == 0);
            if (v && mq.size() >= 0) nextTag = nextTag + 5'd1;
        end
        compareVal("t5_accepted", 32'(acc), 32'(2 * DEPTH + 1));
        drain();
        compareVal("t5_order_empty", 32'(orderQ.size()), 32'd0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, 5'(i + 1), 1'b0);
        end
        compareVal("t6_pre_count", 32'(count), 32'd3);
        compareVal("t6_pre_valid", 32'(res_valid), 32'd1);
        doReset();
        compareVal("t6_count", 32'(count), 32'd0);
        compareVal("t6_res_valid", 32'(res_valid), 32'd0);
        compareVal("t6_in_ready", 32'(in_ready), 32'd1);
        compareVal("t6_res_y", res_y, 32'h0);
        applyStimulus(1'b1, 32'h40000000, 32'h40400000, 5'd7, 1'b1);
        for (int i = 1; i < LAT; i++) applyStimulus(1'b0, 32'h0, 32'h0, '0, 1'b1);
        compareVal("t6_post_valid", 32'(res_valid), 32'd1);
        compareVal("t6_post_y", res_y, 32'h40C00000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fmul_issue_q.md
Name: fmul_issue_q

Overview:
- Sequential issue/result stage that sits directly upstream of the single-precision combinational multiplier and feeds it.
- Buffers operand pairs with tags in an in-order FIFO and presents the head entry to the multiplier.
- Registers the multiplier's combinational result, with its tag, into an output register.
- Uses valid/ready handshakes on both sides so the FPU dispatch and writeback logic can stall independently.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TAG_W, 5, width of the destination tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept an entry this cycle.
- in_x1  in  32  operand 1, IEEE-754 single.
- in_x2  in  32  operand 2, IEEE-754 single.
- in_tag  in  TAG_W  tag of the operation.
- mul_x1  out  32  head operand 1 to the multiplier.
- mul_x2  out  32  head operand 2 to the multiplier.
- mul_y  in  32  combinational product returned by the multiplier.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer accepts the result.
- res_y  out  32  registered product.
- res_tag  out  TAG_W  tag of res_y.
- count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - count=0; read and write pointers =0.
  - res_valid=0, res_y=0, res_tag=0.
  - FIFO contents are don't-care.
  - Reset mid-operation discards all queued and registered results; no partial writes.
- Push:
  - push = in_valid && in_ready.
  - in_ready = (count < DEPTH); registered-state only, never depends on res_ready or on a pop in the same cycle.
  - On full, a same-cycle pop does not free a slot for a push.
  - On push, {in_x1,in_x2,in_tag} is written at the write pointer, which then increments modulo DEPTH.
- Head drive:
  - When count>0, mul_x1/mul_x2 = head entry operands, combinationally from FIFO storage.
  - When count==0, mul_x1=mul_x2=32'h0.
- Capture/pop:
  - cap = (count>0) && (!res_valid || res_ready).
  - On cap: res_y<=mul_y, res_tag<=head tag, res_valid<=1; read pointer increments modulo DEPTH.
  - When res_valid && res_ready && !cap, res_valid<=0; res_y and res_tag hold their last values.
- Occupancy:
  - count increments on push only, decrements on cap only, and is unchanged when both or neither occur.
  - Pointers wrap from DEPTH-1 to 0. count never exceeds DEPTH and never underflows.
- Ordering: results emerge strictly in push order; one result per cycle maximum.
- Latency: a push accepted at edge N is captured at edge N+1 at the earliest, so res_valid is high in the cycle after N+1 (2 edges, input to output).
- Throughput: one op/cycle sustained when res_ready is held high.
- Backpressure:
  - With res_ready=0 and res_valid=1, no capture occurs.
  - The FIFO fills, and in_ready drops once count==DEPTH.
- No arithmetic is performed in this block; mul_y passes through unmodified.

Optional Feature:
- Macro: FMUL_ISSUE_BYPASS_EN.
- When defined:
  - If count==0 and (!res_valid || res_ready) and push, the input bypasses the FIFO.
  - mul_x1/mul_x2 are driven from in_x1/in_x2 that cycle, and mul_y/in_tag are captured directly into the result register at the same edge.
  - count stays 0, so latency is 1 edge.
  - A push that occurs while the FIFO is non-empty never bypasses, preserving order.
- When not defined: every operation passes through the FIFO with the 2-edge latency above; no bypass mux is present.

Test Plan:
- Reset, then push {40000000,40400000,tag 3} with res_ready=1 -> res_valid after 2 edges, res_y=40C00000 (2.0*3.0=6.0), res_tag=3, count returns to 0.
- Back-to-back pushes:
  - Stimulus: 3FC00000*3FC00000 (tag 1), BF800000*40000000 (tag 2), 00000000*40000000 (tag 3), res_ready=1.
  - Response: consecutive cycles 40100000/1, C0000000/2, 00000000/3, in order.
- Hold res_ready=0 and push DEPTH+2 ops -> one op in the result register, count==DEPTH, in_ready=0; further in_valid ignored. Then res_ready=1 -> all DEPTH+1 accepted results drain in order, none lost or duplicated.
- At count==DEPTH, assert in_valid with res_ready=1 (pop this cycle) -> push refused; count goes DEPTH-1; the push is accepted next cycle.
- Push 2*DEPTH+1 ops with res_ready toggling 1/0 every cycle -> pointers wrap correctly; tag sequence preserved, checked against a scoreboard model.
- Assert rst while count==3 and res_valid=1 -> next cycle count=0, res_valid=0, in_ready=1, res_y=0; with FMUL_ISSUE_BYPASS_EN, a push into empty gives res_valid after 1 edge.
